mat_mul_seq: RTL
================

Name: mat_mul_seq

Overview:
Sequencer that drives the combinational inner-product unit (intProd_M) to compute a full N x N signed matrix product C = A x B.
- On start, latches A and B.
- Walks every (row, col) result index, presenting row i of A on lin and column j of B on col.
- Captures the returned n_out/ovf into the result matrix and a sticky overflow flag.
- Sits between the coprocessor register file / instruction decoder and intProd_M; it is the initiator for that unit.

Parameters:
N, 5, matrix dimension (rows = cols = N)
W, 8, signed element width in bits

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a multiply; sampled only in IDLE
mat_a  input  N*N*W  operand A, row-major; element k = N*r+c at bits [N*N*W-1-W*k -: W] (element 0 in MSBs)
mat_b  input  N*N*W  operand B, same packing as mat_a
lin  output  N*W  row i of latched A; element 0 in MSBs (bits [N*W-1 -: W])
col  output  N*W  column j of latched B, element 0 = B[0][j] in MSBs
prod_in  input  W  n_out from intProd_M for the current lin/col (combinational, same cycle)
ovf_in  input  1  ovf from intProd_M for the current lin/col
mat_c  output  N*N*W  result matrix, same packing as mat_a
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when mat_c is complete
ovf  output  1  sticky OR of ovf_in over the current operation

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; i = j = 0.
  - Latched A/B = 0, mat_c = 0, busy = 0, done = 0, ovf = 0.
  - lin/col = 0 (derived from zeroed latches).
- States:
  - IDLE:
    - start=1: latch mat_a/mat_b, clear mat_c and ovf, set i = j = 0, go to RUN.
    - start=0: remain in IDLE, holding mat_c and ovf.
  - RUN (busy=1), each cycle:
    - lin/col are driven combinationally from the latched operands and i, j.
    - At the clock edge: C[i][j] <= prod_in; ovf <= ovf | ovf_in.
    - Index advance: j increments; when j = N-1, j <= 0 and i increments.
    - After writing C[N-1][N-1], go to DONE.
  - DONE:
    - done=1 and busy=0 for exactly one cycle, then return to IDLE.
    - mat_c and ovf hold their values until the next accepted start.
- Timing: start sampled at edge 0; RUN occupies cycles 1..N*N (25 cycles by default); done is high in cycle N*N+1.
  - Next start is accepted no earlier than the cycle after done (back-to-back gap of 1 cycle).
- Operands are latched, so changes to mat_a/mat_b during RUN have no effect.
- start is ignored in RUN and DONE; there is no queuing.
- lin/col are valid only while busy=1. Outside RUN they reflect the latched operands at i = j = 0 and must not be consumed.
- Reset asserted mid-RUN aborts immediately: all state returns to reset values, and done never pulses for the aborted operation.
- No arithmetic is performed here. Saturation/wrap of products is defined by intProd_M, and prod_in is stored verbatim (W bits, signed).
- ovf is a single flag for the whole matrix; it does not identify the element that overflowed.

Test Plan:
1. A = identity (diag 1), B = elements 1..25 row-major → mat_c == B; ovf=0; done exactly at cycle 26 after start; busy high for cycles 1–25.
2. Row 0 of A = 1,2,3,2,5; column 0 of B = 2,3,2,1,1 (remaining elements 0) → C[0][0]=21, all other C = 0, ovf=0.
3. A = all -1; column 0 of B = 2,3,-2,1,-2 → C[r][0] = -2 for every r; ovf=0.
4. A = all -1; column 0 of B = -126,-125,-2,-127,126 → ovf=1 after done and held in IDLE; the next start with identity × identity clears ovf to 0.
5. Pulse start again at RUN cycle 5 and change mat_a at cycle 6 → start is ignored; result equals the product of the originally latched A/B; exactly one done pulse.
6. Assert rst at RUN cycle 10 → busy, done, ovf and mat_c are 0 immediately (asynchronously); no done pulse follows; a fresh start then completes normally in 26 cycles.

(Bench instantiates intProd_M driven by lin/col and feeding prod_in/ovf_in.)

Source files
------------

// File: rtl/mat_mul_seq.sv
// mat_mul_seq: sequencer for an N x N signed matrix product C = A x B.
// It latches both operands on start, then visits each result index (i, j)
// in row-major order. For each index it presents row i of A and column j of B
// to the external inner-product unit and stores that unit's answer into mat_c.
// Overflow reports from the unit are OR-ed into one sticky flag.
module mat_mul_seq #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N*N*W-1:0] mat_a,
  input  logic [N*N*W-1:0] mat_b,
  output logic [N*W-1:0]   lin,
  output logic [N*W-1:0]   col,
  input  logic [W-1:0]     prod_in,
  input  logic             ovf_in,
  output logic [N*N*W-1:0] mat_c,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int MW = N*N*W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [MW-1:0] a_q;
  logic [MW-1:0] b_q;
  logic [IW-1:0] row;
  logic [IW-1:0] cidx;

  // Present row `row` of latched A and column `cidx` of latched B to the inner-product unit
  always_comb begin
    lin = '0;
    col = '0;
    for (int t = 0; t < N; t++) begin
      lin[N*W-1-W*t -: W] = a_q[MW-1-W*(N*int'(row)+t) -: W];
      col[N*W-1-W*t -: W] = b_q[MW-1-W*(N*t+int'(cidx)) -: W];
    end
  end

  // Control FSM: latch operands, walk the indices, collect results, pulse done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      row   <= '0;
      cidx  <= '0;
      mat_c <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= mat_a;
            b_q   <= mat_b;
            mat_c <= '0;
            ovf   <= 1'b0;
            row   <= '0;
            cidx  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          mat_c[MW-1-W*(N*int'(row)+int'(cidx)) -: W] <= prod_in;
          ovf <= ovf | ovf_in;
          if (cidx == LAST) begin
            cidx <= '0;
            if (row == LAST) begin
              row   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            cidx <= cidx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
